// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
// Holds the FSM state encoding and the unit-select decode.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  // Enable vector bit order: {shift, cmp, logic, arith}.
  function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
    logic [3:0] oh;
    oh = 4'b0000;
    unique case (sel)
      UNIT_ARITH: oh = 4'b0001;
      UNIT_LOGIC: oh = 4'b0010;
      UNIT_CMP:   oh = 4'b0100;
      UNIT_SHIFT: oh = 4'b1000;
      default:    oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the "last granted"
// state lives in the parent so it only advances on an actual accept.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    // A lone requester always wins; on contention the one not served last wins.
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Arbitrates two requesters onto the shared ALU units, issues one enable
// pulse per operation and returns a tagged response with a timeout guard.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_fun,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_fun,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_fun,
  output logic             arith_en,
  output logic             logic_en,
  output logic             cmp_en,
  output logic             shift_en,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_flag,

  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             id_q, id_d;
  logic [3:0]       fun_q, fun_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  logic [1:0]       gnt;
  logic [3:0]       unit_en;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (rr_last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    id_d         = id_q;
    fun_d        = fun_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    unit_en      = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          req0_ready = gnt[0];
          req1_ready = gnt[1];
          alu_a_d    = gnt[1] ? req1_a   : req0_a;
          alu_b_d    = gnt[1] ? req1_b   : req0_b;
          fun_d      = gnt[1] ? req1_fun : req0_fun;
          id_d       = gnt[1];
          rr_last_d  = gnt[1];
          state_d    = StIssue;
        end
      end

      StIssue: begin
        unit_en = unit_onehot(fun_q[3:2]);
        cnt_d   = '0;
        state_d = StWait;
      end

      StWait: begin
        // A flag arriving on the last allowed cycle still beats the timeout.
        if (alu_flag) begin
          resp_data_d  = alu_out;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else if (cnt_q == CntLast) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      rr_last_q    <= 1'b1;
      id_q         <= 1'b0;
      fun_q        <= 4'b0000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      id_q         <= id_d;
      fun_q        <= fun_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_fun    = fun_q[1:0];
  assign arith_en   = unit_en[0];
  assign logic_en   = unit_en[1];
  assign cmp_en     = unit_en[2];
  assign shift_en   = unit_en[3];
  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule
